// File: rtl/adder_arbiter.sv
// Round-robin arbiter sequencing NUM_REQ requesters onto one shared combinational FP16 adder.
// Optional macro ADDER_ARB_EXC_EN adds a registered Inf/NaN flag (o_Exc) alongside o_Sum.
module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [16*NUM_REQ-1:0]  i_OpA,
    input  logic [16*NUM_REQ-1:0]  i_OpB,
    output logic [NUM_REQ-1:0]     o_Gnt,
    output logic [15:0]            o_Addend1,
    output logic [15:0]            o_Addend2,
    input  logic [15:0]            i_Sum,
    output logic                   o_Valid,
    output logic [15:0]            o_Sum,
    output logic [ID_W-1:0]        o_Id,
`ifdef ADDER_ARB_EXC_EN
    output logic                   o_Exc,
`endif
    input  logic                   i_Ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_OUT
    } state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] win_idx;
    logic            win_found;
    logic            grant_en;
    logic [15:0]     opa_sel;
    logic [15:0]     opb_sel;
    int              cand;

    // Search starts one past the last winner and wraps, so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr) + 1 + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!win_found && i_Req[cand[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        opa_sel = '0;
        opb_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(win_idx) == k) begin
                opa_sel = i_OpA[16*k +: 16];
                opb_sel = i_OpB[16*k +: 16];
            end
        end
    end

    // A grant is only possible when the adder stage is free; in S_OUT that means the result leaves now.
    assign grant_en = i_Rst_n && win_found &&
                      ((state == S_IDLE) || ((state == S_OUT) && i_Ready));

    always_comb begin
        o_Gnt = '0;
        if (grant_en) begin
            o_Gnt[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state     <= S_IDLE;
            ptr       <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            o_Addend1 <= '0;
            o_Addend2 <= '0;
            o_Valid   <= 1'b0;
            o_Sum     <= '0;
            o_Id      <= '0;
`ifdef ADDER_ARB_EXC_EN
            o_Exc     <= 1'b0;
`endif
        end else if (grant_en) begin
            o_Addend1 <= opa_sel;
            o_Addend2 <= opb_sel;
            id_q      <= win_idx;
            ptr       <= win_idx;
            o_Valid   <= 1'b0;
            state     <= S_ADD;
        end else begin
            case (state)
                S_ADD: begin
                    o_Sum   <= i_Sum;
                    o_Id    <= id_q;
                    o_Valid <= 1'b1;
`ifdef ADDER_ARB_EXC_EN
                    o_Exc   <= (i_Sum[14:10] == 5'h1F);
`endif
                    state   <= S_OUT;
                end
                S_OUT: begin
                    if (i_Ready) begin
                        o_Valid <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a queue-based occupancy model predicts grants and results.
// Define ADDER_ARB_EXC_EN on both files to also check o_Exc.
module tb_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] opa;
    logic [63:0] opb;
    logic [3:0]  gnt;
    logic [15:0] add1;
    logic [15:0] add2;
    logic [15:0] sum_in;
    logic        valid;
    logic [15:0] sum_out;
    logic [1:0]  id;
    logic        ready;
`ifdef ADDER_ARB_EXC_EN
    logic        exc;
`endif

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_Req     (req),
        .i_OpA     (opa),
        .i_OpB     (opb),
        .o_Gnt     (gnt),
        .o_Addend1 (add1),
        .o_Addend2 (add2),
        .i_Sum     (sum_in),
        .o_Valid   (valid),
        .o_Sum     (sum_out),
        .o_Id      (id),
`ifdef ADDER_ARB_EXC_EN
        .o_Exc     (exc),
`endif
        .i_Ready   (ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for adderhalfprecision: exact FP16 sums for the directed pairs, an arbitrary
    // scramble otherwise, since the arbiter only has to route whatever the adder returns.
    function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h3C00_4000: return 16'h4200;
            32'h4000_3C00: return 16'h4200;
            32'h7BFF_7BFF: return 16'h7C00;
            default:       return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
        endcase
    endfunction

    assign sum_in = fake_add(add1, add2);

    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        exc;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  gnt_log[$];
    int          gnt_cyc[$];
    int          m_ptr = NUM_REQ - 1;
    bit          m_adding = 1'b0;
    bit          m_holding = 1'b0;
    bit          new_holding;
    bit          pend_chk = 1'b0;
    logic [15:0] pend_a;
    logic [15:0] pend_b;
    logic [3:0]  exp_gnt;
    logic [3:0]  last_gnt = '0;
    int          win;
    int          c;
    exp_t        e;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [63:0] a, input logic [63:0] b,
                                 input logic rdy);
        @(negedge clk);
        req   = r;
        opa   = a;
        opb   = b;
        ready = rdy;
    endtask

    // Monitor/model: occupancy of the single adder slot and the output slot, plus the RR pointer.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            checkOutput("gnt_in_reset", {28'h0, gnt}, 32'h0);
            checkOutput("valid_in_reset", {31'h0, valid}, 32'h0);
            m_ptr     = NUM_REQ - 1;
            m_adding  = 1'b0;
            m_holding = 1'b0;
            pend_chk  = 1'b0;
            sb_q.delete();
            last_gnt  = '0;
        end else begin
            if (pend_chk) begin
                checkOutput("addend1", {16'h0, add1}, {16'h0, pend_a});
                checkOutput("addend2", {16'h0, add2}, {16'h0, pend_b});
                pend_chk = 1'b0;
            end
            checkOutput("valid", {31'h0, valid}, {31'h0, m_holding});
            if (m_holding) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_nonempty", 32'h0, 32'h1);
                end else begin
                    checkOutput("sum", {16'h0, sum_out}, {16'h0, sb_q[0].sum});
                    checkOutput("id", {30'h0, id}, {30'h0, sb_q[0].id});
`ifdef ADDER_ARB_EXC_EN
                    checkOutput("exc", {31'h0, exc}, {31'h0, sb_q[0].exc});
`endif
                end
            end
            exp_gnt = '0;
            win     = -1;
            if (!m_adding && (!m_holding || ready)) begin
                for (int i = 1; i <= NUM_REQ; i++) begin
                    c = (m_ptr + i) % NUM_REQ;
                    if (win < 0 && req[c]) win = c;
                end
            end
            if (win >= 0) exp_gnt[win] = 1'b1;
            checkOutput("gnt", {28'h0, gnt}, {28'h0, exp_gnt});
            last_gnt = gnt;
            new_holding = m_adding || (m_holding && !ready);
            if (m_holding && ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (win >= 0) begin
                pend_a = opa[16*win +: 16];
                pend_b = opb[16*win +: 16];
                e.id   = 2'(win);
                e.sum  = fake_add(pend_a, pend_b);
                e.exc  = (e.sum[14:10] == 5'h1F);
                sb_q.push_back(e);
                m_ptr    = win;
                pend_chk = 1'b1;
                gnt_log.push_back(exp_gnt);
                gnt_cyc.push_back(cyc);
            end
            m_adding  = (win >= 0);
            m_holding = new_holding;
        end
    end

    bit          pend[4];
    logic [63:0] ra;
    logic [63:0] rb;
    logic [3:0]  rr;

    initial begin
        $display("[TB] adder_arbiter scoreboard bench");
        rst_n = 1'b0;
        req   = '0;
        opa   = '0;
        opb   = '0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of S_ADD discards the in-flight add
        applyStimulus(4'b0001, 64'h0000_0000_0000_4000, 64'h0000_0000_0000_3C00, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_valid", {31'h0, valid}, 32'h0);
        checkOutput("rst_gnt", {28'h0, gnt}, 32'h0);
        checkOutput("rst_sum", {16'h0, sum_out}, 32'h0);
        checkOutput("rst_add1", {16'h0, add1}, 32'h0);
        checkOutput("rst_add2", {16'h0, add2}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req   = '0;

        // Fairness: all four held high; requester 0 must be first after reset
        gnt_log.delete();
        gnt_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1111, 64'h4000_3C00_4000_3C00, 64'h3C00_4000_3C00_4000, 1'b1);
        end
        applyStimulus(4'b0000, '0, '0, 1'b1);
        applyStimulus(4'b0000, '0, '0, 1'b1);
        checkOutput("rr_count", gnt_log.size(), 5);
        if (gnt_log.size() == 5) begin
            checkOutput("rr_0", {28'h0, gnt_log[0]}, 32'h1);
            checkOutput("rr_1", {28'h0, gnt_log[1]}, 32'h2);
            checkOutput("rr_2", {28'h0, gnt_log[2]}, 32'h4);
            checkOutput("rr_3", {28'h0, gnt_log[3]}, 32'h8);
            checkOutput("rr_4", {28'h0, gnt_log[4]}, 32'h1);
            for (int i = 0; i < 4; i++) begin
                checkOutput("rr_spacing", gnt_cyc[i+1] - gnt_cyc[i], 2);
            end
        end

        // Single request: lane 2, 1.0 + 2.0
        applyStimulus(4'b0100, 64'h0000_3C00_0000_0000, 64'h0000_4000_0000_0000, 1'b1);
        #1 checkOutput("single_gnt", {28'h0, gnt}, 32'h4);
        repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

        // Backpressure with requester 1 pending
        applyStimulus(4'b0001, 64'h0000_0000_0000_1111, 64'h0000_0000_0000_2222, 1'b0);
        applyStimulus(4'b0010, 64'h0000_0000_5555_0000, 64'h0000_0000_6666_0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 64'h0000_0000_5555_0000, 64'h0000_0000_6666_0000, 1'b0);
            #1 checkOutput("bp_no_gnt", {28'h0, gnt}, 32'h0);
        end
        applyStimulus(4'b0010, 64'h0000_0000_5555_0000, 64'h0000_0000_6666_0000, 1'b1);
        #1 checkOutput("bp_release_gnt", {28'h0, gnt}, 32'h2);
        applyStimulus(4'b0000, '0, '0, 1'b1);
        applyStimulus(4'b0000, '0, '0, 1'b1);

        // Idle return, then a request the next cycle is granted immediately
        applyStimulus(4'b0100, 64'h0000_7777_0000_0000, 64'h0000_8888_0000_0000, 1'b1);
        #1 checkOutput("idle_valid_low", {31'h0, valid}, 32'h0);
        checkOutput("idle_gnt", {28'h0, gnt}, 32'h4);
        repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

        // Overflow to Inf, then an ordinary sum
        applyStimulus(4'b1000, 64'h7BFF_0000_0000_0000, 64'h7BFF_0000_0000_0000, 1'b1);
        repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);
        applyStimulus(4'b0001, 64'h0000_0000_0000_3C00, 64'h0000_0000_0000_4000, 1'b1);
        repeat (3) applyStimulus(4'b0000, '0, '0, 1'b1);

        // Randomized traffic obeying the hold-until-granted rule
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        ra = '0;
        rb = '0;
        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (last_gnt[k]) begin
                    pend[k] = ($urandom_range(0, 1) == 1);
                    ra[16*k +: 16] = 16'($urandom);
                    rb[16*k +: 16] = 16'($urandom);
                end else if (!pend[k] && $urandom_range(0, 3) == 0) begin
                    pend[k] = 1'b1;
                    if ($urandom_range(0, 7) == 0) begin
                        ra[16*k +: 16] = 16'h7BFF;
                        rb[16*k +: 16] = 16'h7BFF;
                    end else begin
                        ra[16*k +: 16] = 16'($urandom);
                        rb[16*k +: 16] = 16'($urandom);
                    end
                end
                rr[k] = pend[k];
            end
            applyStimulus(rr, ra, rb, ($urandom_range(0, 3) != 0));
        end
        repeat (6) applyStimulus(4'b0000, '0, '0, 1'b1);
        checkOutput("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
